// File: rtl/car_anim_pkg.sv
// Shared constants, state encoding and row-position helper for the elevator car animator.
package car_anim_pkg;

  localparam int NUM_FLOORS   = 5;
  localparam int FLOOR_HEIGHT = 96;
  localparam int CAR_STEP     = 2;
  localparam int DOOR_MAX     = 32;
  localparam int DOOR_STEP    = 4;
  localparam int DOOR_HOLD    = 60;

  localparam int FLOOR_W = $clog2(NUM_FLOORS);
  // One spare bit so the row output matches the 10-bit VGA line counter.
  localparam int Y_W     = $clog2(NUM_FLOORS * FLOOR_HEIGHT) + 1;
  localparam int DOOR_W  = $clog2(DOOR_MAX + 1);
  localparam int HOLD_W  = $clog2(DOOR_HOLD);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MOVE_UP,
    ST_MOVE_DOWN,
    ST_DOOR_OPENING,
    ST_DOOR_OPEN,
    ST_DOOR_CLOSING
  } anim_state_t;

  // Top pixel row of the car when parked at floor f (floor 0 is lowest on screen).
  function automatic logic [Y_W-1:0] floor_y(input logic [FLOOR_W-1:0] f);
    return Y_W'((NUM_FLOORS - 1 - int'(f)) * FLOOR_HEIGHT);
  endfunction

endpackage

// File: rtl/car_animator.sv
// Frame-synchronous car position / door animator; all state advances only on frame_tick
// so the pixel generator sees constant data for a whole visible frame.
module car_animator
  import car_anim_pkg::*;
(
  input  logic               i_pixel_clk,
  input  logic               i_reset,
  input  logic               i_frame_tick,
  input  logic [FLOOR_W-1:0] i_target_floor,
  input  logic [1:0]         i_sim_state,
  input  logic [7:0]         i_people_data,
  output logic [Y_W-1:0]     o_car_y,
  output logic [FLOOR_W-1:0] o_cur_floor,
  output logic [DOOR_W-1:0]  o_door_gap,
  output logic               o_moving,
  output logic               o_arrived,
  output logic [1:0]         o_sim_state_q,
  output logic [7:0]         o_people_q
);

  localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(NUM_FLOORS - 1);
  localparam logic [Y_W-1:0]     Y_STEP    = Y_W'(CAR_STEP);
  localparam logic [DOOR_W-1:0]  D_STEP    = DOOR_W'(DOOR_STEP);
  localparam logic [DOOR_W-1:0]  D_MAX     = DOOR_W'(DOOR_MAX);
  localparam logic [HOLD_W-1:0]  HOLD_LOAD = HOLD_W'(DOOR_HOLD - 1);

  anim_state_t        r_state,   w_state_nxt;
  logic [Y_W-1:0]     r_car_y,   w_car_y_nxt;
  logic [FLOOR_W-1:0] r_cur,     w_cur_nxt;
  logic [FLOOR_W-1:0] r_tgt,     w_tgt_nxt;
  logic [DOOR_W-1:0]  r_door,    w_door_nxt;
  logic [HOLD_W-1:0]  r_hold,    w_hold_nxt;
  logic               r_moving,  w_moving_nxt;
  logic               r_arrived, w_arrived_nxt;
  logic [1:0]         r_sim_q,   w_sim_q_nxt;
  logic [7:0]         r_ppl_q,   w_ppl_q_nxt;

  logic [FLOOR_W-1:0] w_tgt_eff;
  logic               w_step_up;
  logic               w_step_dn;

  always_ff @(posedge i_pixel_clk) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_car_y   <= floor_y('0);
      r_cur     <= '0;
      r_tgt     <= '0;
      r_door    <= '0;
      r_hold    <= '0;
      r_moving  <= 1'b0;
      r_arrived <= 1'b0;
      r_sim_q   <= '0;
      r_ppl_q   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_car_y   <= w_car_y_nxt;
      r_cur     <= w_cur_nxt;
      r_tgt     <= w_tgt_nxt;
      r_door    <= w_door_nxt;
      r_hold    <= w_hold_nxt;
      r_moving  <= w_moving_nxt;
      r_arrived <= w_arrived_nxt;
      r_sim_q   <= w_sim_q_nxt;
      r_ppl_q   <= w_ppl_q_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_car_y_nxt   = r_car_y;
    w_cur_nxt     = r_cur;
    w_tgt_nxt     = r_tgt;
    w_door_nxt    = r_door;
    w_hold_nxt    = r_hold;
    w_arrived_nxt = 1'b0;
    w_sim_q_nxt   = r_sim_q;
    w_ppl_q_nxt   = r_ppl_q;
    w_tgt_eff     = r_tgt;
    w_step_up     = 1'b0;
    w_step_dn     = 1'b0;

    if (i_frame_tick) begin
      w_sim_q_nxt = i_sim_state;
      w_ppl_q_nxt = i_people_data;
      case (r_state)
        ST_IDLE: begin
          w_tgt_eff = (i_target_floor > TOP_FLOOR) ? TOP_FLOOR : i_target_floor;
          w_tgt_nxt = w_tgt_eff;
          w_step_dn = (w_tgt_eff < r_cur);
          w_step_up = (w_tgt_eff > r_cur);
        end
        ST_MOVE_UP:   w_step_up = 1'b1;
        ST_MOVE_DOWN: w_step_dn = 1'b1;
        ST_DOOR_OPENING: begin
          w_door_nxt = r_door + D_STEP;
          if (w_door_nxt == D_MAX) begin
            w_hold_nxt  = HOLD_LOAD;
            w_state_nxt = ST_DOOR_OPEN;
          end
        end
        ST_DOOR_OPEN: begin
          if (r_hold == '0) w_state_nxt = ST_DOOR_CLOSING;
          else              w_hold_nxt  = r_hold - HOLD_W'(1);
        end
        ST_DOOR_CLOSING: begin
          w_door_nxt = r_door - D_STEP;
          if (w_door_nxt == '0) w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase

      // The IDLE departure tick already moves the car, so travel is exactly
      // FLOOR_HEIGHT/CAR_STEP ticks per floor counted from the departure tick.
      if (w_step_up || w_step_dn) begin
        w_car_y_nxt = w_step_up ? (r_car_y - Y_STEP) : (r_car_y + Y_STEP);
        if (w_car_y_nxt == floor_y(w_tgt_eff)) begin
          w_cur_nxt     = w_tgt_eff;
          w_arrived_nxt = 1'b1;
          w_state_nxt   = ST_DOOR_OPENING;
        end else begin
          w_state_nxt = w_step_up ? ST_MOVE_UP : ST_MOVE_DOWN;
        end
      end
    end

    w_moving_nxt = (w_state_nxt == ST_MOVE_UP) || (w_state_nxt == ST_MOVE_DOWN);
  end

  always_comb begin
    o_car_y       = r_car_y;
    o_cur_floor   = r_cur;
    o_door_gap    = r_door;
    o_moving      = r_moving;
    o_arrived     = r_arrived;
    o_sim_state_q = r_sim_q;
    o_people_q    = r_ppl_q;
  end

endmodule

// File: tb/tb_car_animator.sv
// Scoreboard bench for car_animator: stimulus queues hand-computed expectations per tick/reset,
// a monitor pops them one cycle later and checks that outputs hold steady between ticks.
module tb_car_animator;

  typedef struct {
    logic [9:0] y;
    logic [2:0] cur;
    logic [5:0] door;
    logic       mov;
    logic       arr;
    logic [1:0] sim;
    logic [7:0] ppl;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       frame_tick = 1'b0;
  logic [2:0] target_floor = 3'd0;
  logic [1:0] sim_state = 2'd0;
  logic [7:0] people_data = 8'd0;
  logic [9:0] car_y;
  logic [2:0] cur_floor;
  logic [5:0] door_gap;
  logic       moving, arrived;
  logic [1:0] sim_state_q;
  logic [7:0] people_q;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   arr_cnt  = 0;
  int   pcnt     = 0;

  car_animator dut (
    .i_pixel_clk   (clk),
    .i_reset       (reset),
    .i_frame_tick  (frame_tick),
    .i_target_floor(target_floor),
    .i_sim_state   (sim_state),
    .i_people_data (people_data),
    .o_car_y       (car_y),
    .o_cur_floor   (cur_floor),
    .o_door_gap    (door_gap),
    .o_moving      (moving),
    .o_arrived     (arrived),
    .o_sim_state_q (sim_state_q),
    .o_people_q    (people_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  // Monitor: one pop per tick/reset cycle; otherwise outputs must hold and arrived stay low.
  initial begin
    exp_t e, last;
    bit   have_last = 0;
    logic t, r;
    forever begin
      @(posedge clk);
      t = frame_tick;
      r = reset;
      #1;
      if (arrived) arr_cnt++;
      if (t || r) begin
        if (q.size() == 0) begin
          chk("scoreboard_underflow", 1, 0);
        end else begin
          e = q.pop_front();
          chk("car_y", int'(car_y), int'(e.y));
          chk("cur_floor", int'(cur_floor), int'(e.cur));
          chk("door_gap", int'(door_gap), int'(e.door));
          chk("moving", int'(moving), int'(e.mov));
          chk("arrived", int'(arrived), int'(e.arr));
          chk("sim_state_q", int'(sim_state_q), int'(e.sim));
          chk("people_q", int'(people_q), int'(e.ppl));
          last = e;
          have_last = 1;
        end
      end else if (have_last) begin
        chk("hold_car_y", int'(car_y), int'(last.y));
        chk("hold_door_gap", int'(door_gap), int'(last.door));
        chk("hold_moving", int'(moving), int'(last.mov));
        chk("hold_people_q", int'(people_q), int'(last.ppl));
        chk("hold_sim_state_q", int'(sim_state_q), int'(last.sim));
        chk("arrived_width", int'(arrived), 0);
      end
    end
  end

  // Issue one frame tick; b2b keeps frame_tick high from the previous tick (illegal but must step once each).
  task automatic issue(input int y, input int c, input int d, input bit m, input bit a, input bit b2b);
    exp_t e;
    if (!b2b) begin
      @(negedge clk);
      frame_tick  = 1'b0;
      people_data = 8'($urandom);
      sim_state   = 2'($urandom);
      @(negedge clk);
    end else begin
      @(negedge clk);
    end
    pcnt++;
    people_data = 8'(pcnt) ^ 8'h5A;
    sim_state   = 2'(pcnt);
    frame_tick  = 1'b1;
    e.y = 10'(y); e.cur = 3'(c); e.door = 6'(d); e.mov = m; e.arr = a;
    e.sim = sim_state; e.ppl = people_data;
    q.push_back(e);
  endtask

  task automatic do_reset(input bit with_tick);
    exp_t e;
    @(negedge clk);
    frame_tick = with_tick;
    reset = 1'b1;
    e.y = 10'd384; e.cur = 3'd0; e.door = 6'd0; e.mov = 1'b0; e.arr = 1'b0;
    e.sim = 2'd0; e.ppl = 8'd0;
    q.push_back(e);
    @(negedge clk);
    reset = 1'b0;
    frame_tick = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Open 8 ticks, hold 60, close 8.
  task automatic door_cycle(input int y, input int c);
    for (int j = 1; j <= 8; j++) issue(y, c, 4*j, 0, 0, 0);
    for (int j = 1; j <= 60; j++) issue(y, c, 32, 0, 0, 0);
    for (int j = 1; j <= 8; j++) issue(y, c, 32 - 4*j, 0, 0, 0);
  endtask

  initial begin
    // Reset, then parked at floor 0 with target 0
    do_reset(0);
    for (int k = 1; k <= 10; k++) issue(384, 0, 0, 0, 0, 0);
    idle_cycles(3);
    chk("no_arrival_when_idle", arr_cnt, 0);

    // Floor 0 -> 1: 48 ticks, arrival on the last
    target_floor = 3'd1;
    for (int k = 1; k <= 48; k++) issue(384 - 2*k, (k == 48) ? 1 : 0, 0, k < 48, k == 48, 0);
    door_cycle(288, 1);
    issue(288, 1, 0, 0, 0, 0);  // same floor requested: doors stay shut
    idle_cycles(3);
    chk("arrivals_after_first_trip", arr_cnt, 1);

    // Target 7 clamps to top floor; first two ticks back-to-back
    do_reset(0);
    target_floor = 3'd7;
    issue(382, 0, 0, 1, 0, 0);
    issue(380, 0, 0, 1, 0, 1);
    for (int k = 3; k <= 192; k++) issue(384 - 2*k, (k == 192) ? 4 : 0, 0, k < 192, k == 192, 0);
    door_cycle(0, 4);

    // Floor 4 -> 3 with target changed to 1 mid-move; then down to 1
    target_floor = 3'd3;
    for (int k = 1; k <= 48; k++) begin
      if (k == 10) target_floor = 3'd1;
      issue(2*k, (k == 48) ? 3 : 4, 0, k < 48, k == 48, 0);
    end
    door_cycle(96, 3);
    for (int k = 1; k <= 20; k++) issue(96 + 2*k, 3, 0, 1, 0, 0);

    // Reset mid MOVE_DOWN with a coincident tick
    do_reset(1);
    target_floor = 3'd0;
    issue(384, 0, 0, 0, 0, 0);
    issue(384, 0, 0, 0, 0, 0);
    idle_cycles(3);

    for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge clk);
    chk("scoreboard_drained", q.size(), 0);
    chk("total_arrivals", arr_cnt, 3);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/car_animator.md
# car_animator

Frame-synchronous elevator car animator between the elevator controller and the VGA pixel generator. Once per video frame, at the start of vertical blanking, it advances a car position in pixel rows toward the requested floor, then sequences the door open/hold/close animation. It also snapshots controller status so the pixel generator sees data that is constant across each visible frame. All outputs are registered and change only in the cycle after a frame tick, so no tearing occurs mid-frame.

## Interface
- NUM_FLOORS, 5: floors 0 (bottom) .. NUM_FLOORS-1 (top)
- FLOOR_HEIGHT, 96: pixel rows per floor; NUM_FLOORS*FLOOR_HEIGHT ≤ 480
- CAR_STEP, 2: rows moved per frame; FLOOR_HEIGHT is a multiple of CAR_STEP
- DOOR_MAX, 32: fully open door gap, pixels
- DOOR_STEP, 4: gap change per frame; DOOR_MAX is a multiple of DOOR_STEP
- DOOR_HOLD, 60: frames held fully open
- pixel_clk  in  1  pixel clock; the block's only clock
- reset  in  1  synchronous, active-high
- frame_tick  in  1  one-cycle pulse per frame; producer asserts it at horiz_count==0, vert_count==480
- target_floor  in  3  requested floor from the controller
- sim_state  in  2  controller status, snapshotted
- people_data  in  8  controller occupancy data, snapshotted
- car_y  out  10  top pixel row of the car
- cur_floor  out  3  floor the car last arrived at
- door_gap  out  6  current door gap in pixels, 0..DOOR_MAX
- moving  out  1  1 while in MOVE_UP or MOVE_DOWN
- arrived  out  1  one-cycle pulse on arrival
- sim_state_q  out  2  frame-stable copy of sim_state
- people_q  out  8  frame-stable copy of people_data

## Operation
- floor_y(f) = (NUM_FLOORS-1-f)*FLOOR_HEIGHT. With defaults, floor 0 → row 384 and floor 4 → row 0.
- Target clamp: a target_floor ≥ NUM_FLOORS is treated as NUM_FLOORS-1.
- The FSM evaluates only on frame_tick. With no tick, all state holds.
- FSM states are IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPENING, DOOR_OPEN, DOOR_CLOSING.
- IDLE:
  - Latch the clamped target into tgt.
  - tgt < cur_floor → MOVE_DOWN. tgt > cur_floor → MOVE_UP. Equal → stay in IDLE; doors stay shut.
- MOVE_UP: car_y -= CAR_STEP. MOVE_DOWN: car_y += CAR_STEP.
- Arrival: when the updated car_y equals floor_y(tgt):
  - cur_floor ← tgt
  - arrived pulses
  - go to DOOR_OPENING in the same tick.
- Mid-move target changes are ignored. tgt is re-sampled only in IDLE.
- DOOR_OPENING: door_gap += DOOR_STEP. On reaching DOOR_MAX, load hold_cnt = DOOR_HOLD-1 → DOOR_OPEN.
- DOOR_OPEN: decrement hold_cnt. Leave on the tick where hold_cnt==0 → DOOR_CLOSING.
- DOOR_CLOSING: door_gap -= DOOR_STEP. On reaching 0 → IDLE.
- Snapshot: on every frame_tick, in all states, sim_state_q ← sim_state and people_q ← people_data.
- Reset values:
  - state IDLE, car_y = floor_y(0) (384), cur_floor 0, tgt 0
  - door_gap 0, hold_cnt 0, moving 0, arrived 0
  - sim_state_q 0, people_q 0
- Reset mid-operation: any state returns to the reset values in the next cycle. Reset overrides a coincident frame_tick.

## Timing
- Latency: every output updates in the cycle after the frame_tick cycle.
- arrived is high for exactly one pixel_clk cycle per arrival.
- Travel time: |Δfloor|*FLOOR_HEIGHT/CAR_STEP frames. Default one floor = 48 frames.
- Door cycle: DOOR_MAX/DOOR_STEP open frames + DOOR_HOLD + DOOR_MAX/DOOR_STEP close frames. Default 8+60+8 = 76 frames.
- Back-to-back frame_tick (illegal from the timing generator) must still step exactly once per pulse.

## Structure
- Package car_anim_pkg holds:
  - anim_state_t enum
  - default parameter constants
  - function floor_y() (constant multiply)
- Single module, no sub-module. The FSM, position counter, door counter, hold counter and snapshot registers all live in one always_ff plus next-state always_comb.
- Widths are sized from parameters via $clog2 in the package.

## Test plan
- Reset, then 10 ticks with target 0 → car_y 384, door_gap 0, moving 0, arrived never pulses.
- Target 1 at reset → moving rises 1 cycle after the first tick; car_y 382 after tick 1; car_y 288, cur_floor 1, single arrived pulse at tick 48.
- After the previous arrival → door_gap 4, 8 … 32 over 8 ticks; held 60 ticks; closes to 0 in 8 ticks; back in IDLE.
- Target 7 from floor 0 → clamped to 4; arrives at car_y 0 after 192 ticks.
- Target changed from 3 to 1 mid-move → car continues to floor 3; once doors close and IDLE is re-entered, it moves down to floor 1.
- people_data toggled between ticks → people_q changes only in the cycle after each tick; reset asserted mid-MOVE_DOWN → next cycle shows all reset values.
